// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose
//   Hazard sequencer for the IF/ID pipeline register and the PC of a 5-stage
//   MIPS core. It inserts a single bubble on a load-use hazard, and it flushes
//   IF/ID on a taken branch or jump resolved in ID. While data memory is busy,
//   it freezes the whole pipe. A watchdog latches a sticky error if memory stays
//   busy for too long. Saturating performance counters track stall and flush
//   cycles.
//
// Parameters
//   CNT_W        width of the stall/flush performance counters
//   MEM_TIMEOUT  consecutive busy cycles tolerated before ERROR (>= 1)
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   id_rs_i        rs field of the instruction in ID
//   id_rt_i        rt field of the instruction in ID
//   id_uses_rt_i   ID instruction reads rt as a source
//   ex_memread_i   instruction in EX is a load
//   ex_rt_i        destination rt of the load in EX
//   branch_taken_i taken branch resolved in ID
//   jump_i         jump decoded in ID
//   mem_busy_i     data memory not ready this cycle
//   pc_write_o     PC load enable
//   if_id_write_o  IF/ID load enable
//   if_id_flush_o  IF/ID loads a NOP
//   id_ex_bubble_o ID/EX control fields forced to zero
//   pipe_stall_o   freeze ID/EX, EX/MEM and MEM/WB
//   timeout_o      sticky memory-watchdog error
//   stall_cnt_o    cycles with pc_write_o == 0
//   flush_cnt_o    cycles with if_id_flush_o == 1
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       id_rs_i,
   input  logic [4:0]       id_rt_i,
   input  logic             id_uses_rt_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rt_i,
   input  logic             branch_taken_i,
   input  logic             jump_i,
   input  logic             mem_busy_i,
   output logic             pc_write_o,
   output logic             if_id_write_o,
   output logic             if_id_flush_o,
   output logic             id_ex_bubble_o,
   output logic             pipe_stall_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERROR    = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              timeout_q, timeout_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic load_use;

   // Register 0 is hard-wired to zero, so a load targeting it can never
   // create a real dependency.
   assign load_use = ex_memread_i && (ex_rt_i != 5'd0) &&
                     ((ex_rt_i == id_rs_i) ||
                      (id_uses_rt_i && (ex_rt_i == id_rt_i)));

   // Mealy control outputs. MEM_WAIT with memory ready behaves exactly like
   // RUN, so only ERROR and mem_busy_i select the frozen behaviour. A branch
   // seen while busy is ignored here; ID is frozen, so it is seen again later.
   always_comb begin
      pc_write_o     = 1'b1;
      if_id_write_o  = 1'b1;
      if_id_flush_o  = 1'b0;
      id_ex_bubble_o = 1'b0;
      pipe_stall_o   = 1'b0;
      if (rst_i) begin
         pc_write_o     = 1'b0;
         if_id_write_o  = 1'b0;
         if_id_flush_o  = 1'b1;
         id_ex_bubble_o = 1'b1;
      end else if ((state_q == ST_ERROR) || mem_busy_i) begin
         pc_write_o    = 1'b0;
         if_id_write_o = 1'b0;
         pipe_stall_o  = 1'b1;
      end else if (load_use) begin
         // A simultaneous branch is deferred: ID holds, so it is retried.
         pc_write_o     = 1'b0;
         if_id_write_o  = 1'b0;
         id_ex_bubble_o = 1'b1;
      end else if (branch_taken_i || jump_i) begin
         if_id_flush_o = 1'b1;
      end
   end

   // Next-state logic for the memory-wait watchdog FSM.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      case (state_q)
         ST_RUN: begin
            if (mem_busy_i) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end
         end
         ST_MEM_WAIT: begin
            if (mem_busy_i) begin
               if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                  // Hold the count here so it never overflows its width.
                  state_d   = ST_ERROR;
                  timeout_d = 1'b1;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
            end else begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end
         end
         ST_ERROR: begin
            state_d   = ST_ERROR;
            timeout_d = 1'b1;
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // Saturating performance counters. Reset cycles are never counted,
   // because the reset branch below overrides these next values.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_write_o && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (if_id_flush_o && (flush_cnt_q != {CNT_W{1'b1}}))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign timeout_o   = timeout_q;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule
